ahb2apb_bridge: RTL and testbench



---
 rtl/ahb2apb_bridge_pkg.sv | 32 +++
 rtl/ahb2apb_bridge.sv | 127 ++++++++++++
 tb/tb_ahb2apb_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2apb_bridge_pkg.sv
// rtl/ahb2apb_bridge_pkg.sv - shared types and constants for the AHB-Lite to APB bridge
package ahb2apb_bridge_pkg;

  // AHB transfer types and responses
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // Slot field inside PADDR, and top bit of the 256 MB decoder window offset
  localparam int APB_SLOT_LSB  = 12;
  localparam int APB_SLOT_BITS = 2;
  localparam int WINDOW_MSB    = 27;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WCAP   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } bridge_state_t;

  // States in which a new AHB address phase may be sampled
  function automatic logic can_accept(input bridge_state_t st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERR2);
  endfunction

endpackage

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB-Lite slave converting each transfer into an APB SETUP/ACCESS sequence
// All outputs come from registers or from a decode of the registered state.
module ahb2apb_bridge
  import ahb2apb_bridge_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 14,
  parameter int NUM_PSEL       = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [AHB_DATA_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADY_OUT,
  output logic [1:0]                HRESP,
  output logic [AHB_DATA_WIDTH-1:0] HRDATA,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_PSEL-1:0]       PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [AHB_DATA_WIDTH-1:0] PWDATA,
  input  logic [AHB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  bridge_state_t             state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [AHB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic                      accept;
  logic                      mapped;
  logic [APB_SLOT_BITS-1:0]  slot;
  logic                      unused_bits;

  assign accept = HSEL & HTRANS[1] & HREADY;
  // Only the first 16 KB of the window is backed by the four 4 KB slots
  assign mapped = (HADDR[WINDOW_MSB:APB_ADDR_WIDTH] == '0);
  assign slot   = paddr_q[APB_SLOT_LSB +: APB_SLOT_BITS];

  assign unused_bits = ^{HADDR[AHB_ADDR_WIDTH-1:WINDOW_MSB+1], HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;

    if (can_accept(state_q)) begin
      state_d = ST_IDLE;
      if (accept) begin
        paddr_d  = HADDR[APB_ADDR_WIDTH-1:0];
        pwrite_d = HWRITE;
        if (!mapped) begin
          state_d = ST_ERR1;
        end else if (HWRITE) begin
          state_d = ST_WCAP;
        end else begin
          state_d = ST_SETUP;
        end
      end
    end else begin
      case (state_q)
        ST_WCAP: begin
          pwdata_d = HWDATA;
          state_d  = ST_SETUP;
        end
        ST_SETUP: begin
          state_d = ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              state_d = ST_ERR1;
            end else begin
              state_d = ST_DONE;
              if (!pwrite_q) begin
                hrdata_d = PRDATA;
              end
            end
          end
        end
        ST_ERR1: begin
          state_d = ST_ERR2;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign HREADY_OUT = can_accept(state_q);
  assign HRESP      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign PSEL       = ((state_q == ST_SETUP) || (state_q == ST_ACCESS))
                      ? (NUM_PSEL'(1) << slot) : '0;
  assign PENABLE    = (state_q == ST_ACCESS);
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign HRDATA     = hrdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb/tb_ahb2apb_bridge.sv - directed and randomized bench for ahb2apb_bridge against a transfer-level model
module tb_ahb2apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADY_OUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [13:0] PADDR;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  // Transfer-level model state: what the AHB master should have observed so far
  logic [31:0] hrdata_m;
  logic [31:0] pwdata_m;

  ahb2apb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADY_OUT(HREADY_OUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] addr, input logic wr);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = addr;
    HWRITE = wr;
  endtask

  task automatic check_idle();
    chk("idle_hready", {31'd0, HREADY_OUT}, 32'd1);
    chk("idle_hresp", {30'd0, HRESP}, 32'd0);
    chk("idle_psel", {28'd0, PSEL}, 32'd0);
    chk("idle_penable", {31'd0, PENABLE}, 32'd0);
  endtask

  // Runs one transfer whose address phase is already on the bus; returns mid-cycle
  // of the final response cycle so the caller may overlap the next address phase.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int nwait, input logic err);
    logic       mapped;
    int         s, last_acc, total;
    logic [3:0] onehot;
    mapped   = (addr[27:14] == 14'd0);
    onehot   = 4'b0001 << addr[13:12];
    s        = wr ? 2 : 1;
    last_acc = s + 1 + nwait;
    total    = mapped ? (last_acc + 1 + (err ? 1 : 0)) : 2;
    for (int k = 1; k <= total; k++) begin
      @(posedge HCLK);
      #1;
      if (k == 1) begin
        HTRANS = 2'b00;
        HSEL   = 1'($urandom);
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HWDATA = wdata;
      end else begin
        HWDATA = $urandom;
      end
      if (mapped && k > s && k <= last_acc) begin
        PREADY  = (k == last_acc);
        PSLVERR = err && (k == last_acc);
        PRDATA  = (k == last_acc) ? rdata : $urandom;
      end else begin
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
      end
      @(negedge HCLK);
      if (!mapped) begin
        chk("unm_psel", {28'd0, PSEL}, 32'd0);
        chk("unm_hready", {31'd0, HREADY_OUT}, (k == 2) ? 32'd1 : 32'd0);
        chk("unm_hresp", {30'd0, HRESP}, 32'd1);
      end else if (k < s) begin
        chk("wcap_hready", {31'd0, HREADY_OUT}, 32'd0);
        chk("wcap_psel", {28'd0, PSEL}, 32'd0);
      end else if (k <= last_acc) begin
        if (wr) pwdata_m = wdata;
        chk("apb_hready", {31'd0, HREADY_OUT}, 32'd0);
        chk("apb_psel", {28'd0, PSEL}, {28'd0, onehot});
        chk("apb_penable", {31'd0, PENABLE}, (k == s) ? 32'd0 : 32'd1);
        chk("apb_paddr", {18'd0, PADDR}, {18'd0, addr[13:0]});
        chk("apb_pwrite", {31'd0, PWRITE}, {31'd0, wr});
        chk("apb_pwdata", PWDATA, pwdata_m);
      end else begin
        if (!err && !wr && k == last_acc + 1) hrdata_m = rdata;
        chk("end_psel", {28'd0, PSEL}, 32'd0);
        chk("end_penable", {31'd0, PENABLE}, 32'd0);
        chk("end_hready", {31'd0, HREADY_OUT}, (err && k == last_acc + 1) ? 32'd0 : 32'd1);
        chk("end_hresp", {30'd0, HRESP}, err ? 32'd1 : 32'd0);
      end
      chk("hrdata", HRDATA, hrdata_m);
    end
  endtask

  task automatic idle_cycle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    @(posedge HCLK);
    @(negedge HCLK);
    check_idle();
  endtask

  initial begin
    logic [31:0] a, wd, rd;
    logic        wr, er;
    int          nw;
    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    hrdata_m = '0;
    pwdata_m = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_idle();
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_paddr", {18'd0, PADDR}, 32'd0);
    chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    HRESETn = 1'b1;
    idle_cycle();

    // Read slot 1, zero wait states
    present(32'h7000_1004, 1'b0);
    xfer(32'h7000_1004, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    idle_cycle();

    // Write slot 3 with two PREADY-low cycles
    present(32'h7000_3000, 1'b1);
    xfer(32'h7000_3000, 1'b1, 32'h1234_5678, 32'h0, 2, 1'b0);
    idle_cycle();

    // Unmapped read
    present(32'h7000_4000, 1'b0);
    xfer(32'h7000_4000, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    idle_cycle();

    // Peripheral error on read: HRDATA must keep DEADBEEF
    present(32'h7000_0000, 1'b0);
    xfer(32'h7000_0000, 1'b0, 32'h0, 32'hBAD0_BAD0, 1, 1'b1);
    idle_cycle();

    // Back-to-back write then read, second address in the DONE cycle
    present(32'h7000_2010, 1'b1);
    xfer(32'h7000_2010, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    present(32'h7000_0024, 1'b0);
    xfer(32'h7000_0024, 1'b0, 32'h0, 32'h5555_AAAA, 1, 1'b0);
    idle_cycle();

    // A request with bus HREADY low must be ignored
    present(32'h7000_1000, 1'b0);
    HREADY = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    check_idle();
    HREADY = 1'b1;
    xfer(32'h7000_1000, 1'b0, 32'h0, 32'h0F0F_0F0F, 0, 1'b0);
    idle_cycle();

    // Randomized transfers, some chained through DONE/ERR2
    for (int i = 0; i < 60; i++) begin
      a = 32'h7000_0000 | ($urandom & 32'h0000_3FFF);
      if ($urandom_range(0, 4) == 0) a = a | (32'($urandom_range(1, 16383)) << 14);
      wr = 1'($urandom);
      wd = $urandom;
      rd = $urandom;
      nw = $urandom_range(0, 3);
      er = ($urandom_range(0, 5) == 0);
      present(a, wr);
      xfer(a, wr, wd, rd, nw, er);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset in the middle of an ACCESS stall
    present(32'h7000_2008, 1'b0);
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HSEL   = 1'b0;
    PREADY = 1'b0;
    @(posedge HCLK);
    #1;
    PREADY = 1'b0;
    @(negedge HCLK);
    chk("pre_rst_penable", {31'd0, PENABLE}, 32'd1);
    chk("pre_rst_psel", {28'd0, PSEL}, 32'd4);
    #1;
    HRESETn = 1'b0;
    #1;
    hrdata_m = '0;
    pwdata_m = '0;
    check_idle();
    chk("arst_hrdata", HRDATA, 32'd0);
    chk("arst_paddr", {18'd0, PADDR}, 32'd0);
    chk("arst_pwdata", PWDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    PREADY  = 1'b1;
    idle_cycle();

    // Recovery after reset
    present(32'h7000_3FFC, 1'b1);
    xfer(32'h7000_3FFC, 1'b1, 32'hA5A5_5A5A, 32'h0, 0, 1'b0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
